// File: rtl/vram_bsram_responder.sv
// Video RAM responder: byte writes, 32-bit word reads over a synchronous block RAM,
// with refresh busy periods and a full memory clear after every reset.
module vram_bsram_responder #(
    parameter int unsigned ADDR_BITS      = 14,
    parameter int unsigned REFRESH_CYCLES = 4,
    parameter logic [31:0] INIT_VALUE     = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mreq_n,
    input  logic [22:0] address,
    input  logic        wr_n,
    input  logic        rd_n,
    input  logic        rfsh_n,
    input  logic [7:0]  wdata,
    output logic [31:0] rdata,
    output logic        rdata_en,
    output logic        sdram_init_busy,
    output logic        sdram_busy
);

    localparam int unsigned WORD_BITS = ADDR_BITS - 2;
    localparam int unsigned DEPTH     = 1 << WORD_BITS;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        IDLE    = 3'd1,
        WR      = 3'd2,
        RD_WAIT = 3'd3,
        RD_DATA = 3'd4,
        RFSH    = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [WORD_BITS-1:0]   r_init_cnt;
    logic [CNT_W-1:0]       r_rfsh_cnt;
    logic [WORD_BITS-1:0]   r_rd_word;
    logic [31:0]            r_rdata;
    logic                   r_rdata_en;
    logic                   r_init_busy;
    logic                   r_busy;
    logic [31:0]            r_mem [0:DEPTH-1];

    logic                   w_mem_we;
    logic [3:0]             w_mem_be;
    logic [WORD_BITS-1:0]   w_mem_waddr;
    logic [31:0]            w_mem_wdata;
    logic                   w_accept_rd;
    logic                   w_accept_rfsh;
    logic                   w_unused;

    // Upper address bits wrap onto the implemented memory.
    assign w_unused = ^address[22:ADDR_BITS];

    assign w_accept_rfsh = (r_state == IDLE) && !mreq_n && !rfsh_n;
    assign w_accept_rd   = (r_state == IDLE) && !mreq_n && rfsh_n && wr_n && !rd_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus the single memory write port (init clear or byte write).
    always_comb begin
        w_next      = r_state;
        w_mem_we    = 1'b0;
        w_mem_be    = 4'b0000;
        w_mem_waddr = r_init_cnt;
        w_mem_wdata = INIT_VALUE;
        case (r_state)
            INIT: begin
                w_mem_we = 1'b1;
                w_mem_be = 4'b1111;
                if (r_init_cnt == WORD_BITS'(DEPTH - 1)) begin
                    w_next = IDLE;
                end
            end
            IDLE: begin
                if (!mreq_n) begin
                    if (!rfsh_n) begin
                        w_next = RFSH;
                    end else if (!wr_n) begin
                        w_next      = WR;
                        w_mem_we    = 1'b1;
                        w_mem_be    = 4'(4'b0001 << address[1:0]);
                        w_mem_waddr = address[ADDR_BITS-1:2];
                        w_mem_wdata = {4{wdata}};
                    end else if (!rd_n) begin
                        w_next = RD_WAIT;
                    end
                end
            end
            WR:      w_next = IDLE;
            RD_WAIT: w_next = RD_DATA;
            RD_DATA: w_next = IDLE;
            RFSH: begin
                if (r_rfsh_cnt == CNT_W'(0)) begin
                    w_next = IDLE;
                end
            end
            default: w_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_init_cnt  <= '0;
            r_rfsh_cnt  <= '0;
            r_rd_word   <= '0;
            r_rdata_en  <= 1'b0;
            r_init_busy <= 1'b1;
            r_busy      <= 1'b1;
        end else begin
            r_rdata_en  <= (w_next == RD_DATA);
            r_init_busy <= (w_next == INIT);
            r_busy      <= (w_next != IDLE);
            if (r_state == INIT) begin
                r_init_cnt <= r_init_cnt + WORD_BITS'(1);
            end
            if (w_accept_rd) begin
                r_rd_word <= address[ADDR_BITS-1:2];
            end
            if (w_accept_rfsh) begin
                r_rfsh_cnt <= CNT_W'(REFRESH_CYCLES - 1);
            end else if ((r_state == RFSH) && (r_rfsh_cnt != CNT_W'(0))) begin
                r_rfsh_cnt <= r_rfsh_cnt - CNT_W'(1);
            end
        end
    end

    // Block RAM: byte-lane write port and registered read port.
    always_ff @(posedge clk) begin
        if (w_mem_we && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mem_be[b]) begin
                    r_mem[w_mem_waddr][b*8 +: 8] <= w_mem_wdata[b*8 +: 8];
                end
            end
        end
        if (reset) begin
            r_rdata <= 32'h0;
        end else if (r_state == RD_WAIT) begin
            r_rdata <= r_mem[r_rd_word];
        end
    end

    assign rdata           = r_rdata;
    assign rdata_en        = r_rdata_en;
    assign sdram_init_busy = r_init_busy;
    assign sdram_busy      = r_busy;

endmodule

// File: tb/tb_vram_bsram_responder.sv
// Self-checking bench for vram_bsram_responder using a byte-array memory model.
module tb_vram_bsram_responder;

    localparam int unsigned ADDR_BITS = 14;
    localparam int unsigned RC        = 4;
    localparam int unsigned MEM_BYTES = 1 << ADDR_BITS;
    localparam int unsigned WORDS     = MEM_BYTES / 4;

    logic        clk;
    logic        reset;
    logic        mreq_n;
    logic [22:0] address;
    logic        wr_n;
    logic        rd_n;
    logic        rfsh_n;
    logic [7:0]  wdata;
    logic [31:0] rdata;
    logic        rdata_en;
    logic        sdram_init_busy;
    logic        sdram_busy;

    int checks   = 0;
    int failures = 0;
    logic [7:0]  model_mem [0:MEM_BYTES-1];
    logic [31:0] last_rd;

    vram_bsram_responder #(
        .ADDR_BITS(ADDR_BITS),
        .REFRESH_CYCLES(RC),
        .INIT_VALUE(32'h00000000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mreq_n(mreq_n),
        .address(address),
        .wr_n(wr_n),
        .rd_n(rd_n),
        .rfsh_n(rfsh_n),
        .wdata(wdata),
        .rdata(rdata),
        .rdata_en(rdata_en),
        .sdram_init_busy(sdram_init_busy),
        .sdram_busy(sdram_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_word(input logic [22:0] a);
        int b;
        b = int'(a[ADDR_BITS-1:0]) & ~3;
        return {model_mem[b+3], model_mem[b+2], model_mem[b+1], model_mem[b]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(MEM_BYTES); i++) model_mem[i] = 8'h00;
        last_rd = 32'h0;
    endtask

    task automatic set_idle();
        mreq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; rfsh_n = 1'b1;
    endtask

    // Counts negedges with init busy high (current one included), bounded.
    task automatic wait_init(output int n, output int rd_seen);
        n = 0; rd_seen = 0;
        while (sdram_init_busy === 1'b1 && n < 6000) begin
            if (rdata_en !== 1'b0) rd_seen++;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [22:0] a, input logic [7:0] d);
        mreq_n = 1'b0; wr_n = 1'b0; address = a; wdata = d;
        @(negedge clk);
        set_idle();
        checks++;
        if (sdram_busy !== 1'b1 || rdata_en !== 1'b0) begin
            failures++;
            $display("FAIL wr_cycle: busy=%b rdata_en=%b expected busy=1 rdata_en=0", sdram_busy, rdata_en);
        end
        @(negedge clk);
        checks++;
        if (sdram_busy !== 1'b0 || rdata_en !== 1'b0) begin
            failures++;
            $display("FAIL wr_done: busy=%b rdata_en=%b expected busy=0 rdata_en=0", sdram_busy, rdata_en);
        end
        checks++;
        if (rdata !== last_rd) begin
            failures++;
            $display("FAIL rdata_hold: got %h expected %h", rdata, last_rd);
        end
        model_mem[int'(a[ADDR_BITS-1:0])] = d;
    endtask

    // Read with optional ignored write poked while the read is in flight.
    task automatic do_read(input logic [22:0] a, input bit poke);
        logic [31:0] exp;
        exp = model_word(a);
        mreq_n = 1'b0; rd_n = 1'b0; address = a;
        @(negedge clk);
        if (poke) begin
            rd_n = 1'b1; wr_n = 1'b0; address = 23'($urandom); wdata = 8'($urandom);
        end else begin
            set_idle();
        end
        checks++;
        if (sdram_busy !== 1'b1 || rdata_en !== 1'b0) begin
            failures++;
            $display("FAIL rd_wait: busy=%b rdata_en=%b expected busy=1 rdata_en=0", sdram_busy, rdata_en);
        end
        @(negedge clk);
        set_idle();
        checks++;
        if (rdata_en !== 1'b1 || rdata !== exp) begin
            failures++;
            $display("FAIL rd_data addr=%h: rdata_en=%b rdata=%h expected 1 %h", a, rdata_en, rdata, exp);
        end
        @(negedge clk);
        checks++;
        if (rdata_en !== 1'b0 || sdram_busy !== 1'b0 || rdata !== exp) begin
            failures++;
            $display("FAIL rd_after: rdata_en=%b busy=%b rdata=%h expected 0 0 %h", rdata_en, sdram_busy, rdata, exp);
        end
        last_rd = exp;
    endtask

    task automatic test_reset();
        int n, rs;
        reset = 1'b1;
        set_idle(); address = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sdram_init_busy !== 1'b1 || sdram_busy !== 1'b1 || rdata_en !== 1'b0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: init=%b busy=%b en=%b rdata=%h expected 1 1 0 0",
                     sdram_init_busy, sdram_busy, rdata_en, rdata);
        end
        model_clear();
        reset = 1'b0;
        wait_init(n, rs);
        checks++;
        if (n != int'(WORDS)) begin
            failures++;
            $display("FAIL init_len: got %0d expected %0d", n, WORDS);
        end
        checks++;
        if (sdram_busy !== 1'b0 || rs != 0) begin
            failures++;
            $display("FAIL init_end: busy=%b rdata_en_seen=%0d expected 0 0", sdram_busy, rs);
        end
        do_read(23'h001FFC, 1'b0);
    endtask

    task automatic test_byte_write();
        do_write(23'h000100, 8'h11);
        do_write(23'h000101, 8'h22);
        do_write(23'h000102, 8'h33);
        do_write(23'h000103, 8'h44);
        checks++;
        if (model_word(23'h000102) !== 32'h44332211) begin
            failures++;
            $display("FAIL model_pack: got %h expected 44332211", model_word(23'h000102));
        end
        do_read(23'h000102, 1'b0);
    endtask

    task automatic test_wrap();
        do_write(23'h404001, 8'hA5);
        do_read(23'h000000, 1'b0);
        checks++;
        if (last_rd !== 32'h0000A500 || rdata !== 32'h0000A500) begin
            failures++;
            $display("FAIL wrap: got %h expected 0000a500", rdata);
        end
    endtask

    task automatic test_refresh();
        mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0; address = 23'h000100;
        for (int i = 0; i < 2 * (int'(RC) + 1); i++) begin
            logic exp_busy;
            exp_busy = ((i % (int'(RC) + 1)) < int'(RC));
            @(negedge clk);
            checks++;
            if (sdram_busy !== exp_busy || rdata_en !== 1'b0) begin
                failures++;
                $display("FAIL rfsh_cyc%0d: busy=%b en=%b expected %b 0", i, sdram_busy, rdata_en, exp_busy);
            end
        end
        set_idle();
        do_read(23'h000100, 1'b0);
    endtask

    task automatic test_wr_rd_both();
        mreq_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0; address = 23'h000205; wdata = 8'h5C;
        @(negedge clk);
        set_idle();
        @(negedge clk);
        checks++;
        if (sdram_busy !== 1'b0 || rdata_en !== 1'b0) begin
            failures++;
            $display("FAIL wr_rd_both: busy=%b en=%b expected 0 0", sdram_busy, rdata_en);
        end
        model_mem[int'(12'h205)] = 8'h5C;
        do_read(23'h000204, 1'b0);
    endtask

    // mreq_n held low with writes: only every other edge accepts.
    task automatic test_back_to_back();
        logic [22:0] a [4];
        logic [7:0]  d [4];
        a[0] = 23'h000400; a[1] = 23'h000404; a[2] = 23'h000408; a[3] = 23'h00040C;
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(1, 255));
        mreq_n = 1'b0; wr_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            address = a[i]; wdata = d[i];
            @(negedge clk);
            checks++;
            if (sdram_busy !== ((i % 2) == 0)) begin
                failures++;
                $display("FAIL b2b_busy%0d: got %b expected %b", i, sdram_busy, (i % 2) == 0);
            end
        end
        set_idle();
        model_mem[int'(a[0][ADDR_BITS-1:0])] = d[0];
        model_mem[int'(a[2][ADDR_BITS-1:0])] = d[2];
        for (int i = 0; i < 4; i++) do_read(a[i], 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            logic [22:0] a;
            a = 23'($urandom);
            if ($urandom_range(0, 3) == 0) a[ADDR_BITS-1:4] = '0;
            if ($urandom_range(0, 1) == 0) do_write(a, 8'($urandom));
            else do_read(a, $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_read();
        int n, rs;
        do_write(23'h000200, 8'hEF);
        do_write(23'h000300, 8'h77);
        mreq_n = 1'b0; rd_n = 1'b0; address = 23'h000200;
        @(negedge clk);
        set_idle();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (rdata_en !== 1'b0 || sdram_init_busy !== 1'b1 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset: en=%b init=%b rdata=%h expected 0 1 0", rdata_en, sdram_init_busy, rdata);
        end
        reset = 1'b0;
        model_clear();
        mreq_n = 1'b0; wr_n = 1'b0; address = 23'h000300; wdata = 8'hFF;
        wait_init(n, rs);
        set_idle();
        checks++;
        if (n != int'(WORDS) || rs != 0) begin
            failures++;
            $display("FAIL reinit: len=%0d rdata_en_seen=%0d expected %0d 0", n, rs, WORDS);
        end
        do_read(23'h000200, 1'b0);
        do_read(23'h000300, 1'b0);
        do_read(23'h000100, 1'b0);
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_wrap();
        test_refresh();
        test_wr_rd_both();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_bsram_responder.md
VRAM_BSRAM_RESPONDER -- requirements
Module: vram_bsram_responder

Interface
REQ-001 Parameter ADDR_BITS, default 14, byte-address width of the implemented memory (2^ADDR_BITS bytes, 2^(ADDR_BITS-2) 32-bit words).
REQ-002 Parameter REFRESH_CYCLES, default 4, busy duration of a refresh request (range 1..15).
REQ-003 Parameter INIT_VALUE, default 32'h00000000, word written to every location during initialization.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  reset, synchronous to clk, active-high.
REQ-006 mreq_n  input  1  request strobe, active-low; sampled every clk.
REQ-007 address  input  23  byte address; only address[ADDR_BITS-1:0] used, upper bits ignored (wrap).
REQ-008 wr_n  input  1  write qualifier, active-low.
REQ-009 rd_n  input  1  read qualifier, active-low.
REQ-010 rfsh_n  input  1  refresh qualifier, active-low.
REQ-011 wdata  input  8  write byte.
REQ-012 rdata  output  32  read word.
REQ-013 rdata_en  output  1  one-cycle read-data-valid pulse.
REQ-014 sdram_init_busy  output  1  high while initialization clear runs.
REQ-015 sdram_busy  output  1  high while a request is in progress.

Function
REQ-016 State machine states SHALL be INIT, IDLE, WR, RD_WAIT, RD_DATA, RFSH; sdram_busy SHALL equal (state != IDLE).
REQ-017 Request accepted at a clk edge only when state==IDLE and mreq_n==0; requests in any other state SHALL be ignored, not queued.
REQ-018 Priority at acceptance: rfsh_n==0 -> refresh; else wr_n==0 -> write; else rd_n==0 -> read; else no action, stay IDLE.
REQ-019 Write: at the accept edge the byte lane address[1:0] of word address[ADDR_BITS-1:2] SHALL take wdata, other lanes unchanged; state -> WR for exactly one cycle -> IDLE; no rdata_en.
REQ-020 Read: accept edge -> RD_WAIT (sync BSRAM read) -> RD_DATA -> IDLE; rdata_en SHALL be 1 exactly during RD_DATA, i.e. the second cycle after the accept edge.
REQ-021 rdata SHALL present the full 32-bit word at address[ADDR_BITS-1:2] during RD_DATA and hold that value until the next RD_DATA.
REQ-022 Next request may be accepted in the cycle after RD_DATA (read-to-read issue interval 3 cycles; write-to-write 2 cycles).
REQ-023 Refresh: memory untouched; state RFSH for exactly REFRESH_CYCLES cycles (down-counter) -> IDLE; no rdata_en.
REQ-024 wr_n and rd_n both low: write only, no rdata_en.
REQ-025 INIT: word counter from 0 to 2^(ADDR_BITS-2)-1, one word written with INIT_VALUE per cycle; after last word -> IDLE; sdram_init_busy SHALL be 1 exactly while state==INIT.
REQ-026 A write in the same cycle a read word is being fetched is impossible by construction (single port, one request in flight).

Reset
REQ-027 While reset==1 at a clk edge: state -> INIT, word counter -> 0, refresh counter -> 0, rdata_en -> 0, rdata -> 32'h0.
REQ-028 Outputs after reset: sdram_init_busy=1, sdram_busy=1, rdata_en=0, rdata=0.
REQ-029 Reset mid-operation SHALL abort any read (no rdata_en) or refresh and restart the full clear; memory content before reset is not preserved.

Verification
REQ-030 Reset, ADDR_BITS=14 -> sdram_init_busy high for exactly 4096 cycles after reset release, then sdram_busy=0; read of address 0x1FFC returns 32'h00000000.
REQ-031 Write 0x11,0x22,0x33,0x44 to 0x0100..0x0103, then read 0x0102 -> rdata=32'h44332211, rdata_en single pulse two cycles after accept.
REQ-032 Write 0xA5 to address 23'h404001 -> read of 0x0000 returns 32'h0000A500 (upper bits ignored).
REQ-033 Refresh request (rfsh_n=0, rd_n=0) -> sdram_busy high exactly 4 cycles, no rdata_en; mreq_n held low throughout -> second request accepted only in first cycle back in IDLE.
REQ-034 Read accepted, reset asserted in RD_WAIT -> no rdata_en, sdram_init_busy=1 next cycle, memory re-cleared.
REQ-035 mreq_n=0 during INIT with wr_n=0 -> ignored; location still INIT_VALUE after init.
